// File: rtl/whack_game_core.sv
// Single-clock whack-a-mole core: clock-enable ticks, game FSM, LFSR mole
// placement, hit/miss scoring, countdown and display mux.
module whack_game_core #(
  parameter int          N_MOLES      = 16,
  parameter int          CLK_HZ       = 100_000_000,
  parameter int          GAME_SECONDS = 30,
  parameter int          SCORE_MAX    = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [1:0]         mode_i,
  input  logic               start_i,
  input  logic [N_MOLES-1:0] switches_i,
  output logic [N_MOLES-1:0] moles_o,
  output logic [1:0]         state_o,
  output logic [6:0]         time_left_o,
  output logic [13:0]        score_o,
  output logic [7:0]         misses_o,
  output logic [13:0]        display_o
);
  localparam int HALF = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int IW   = $clog2(N_MOLES);
  localparam logic [15:0] TAPS = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_OVER = 2'b10
  } state_e;

  function automatic logic [13:0] sat_score_inc(input logic [13:0] s);
    return (s < 14'(SCORE_MAX)) ? s + 14'd1 : 14'(SCORE_MAX);
  endfunction

  function automatic logic [7:0] sat_miss_add(input logic [7:0] m, input logic [1:0] n);
    logic [8:0] sum;
    sum = {1'b0, m} + {7'b0, n};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  logic [N_MOLES-1:0] sw_s1_q, sw_s2_q, sw_prev_q;
  logic               st_s1_q, st_s2_q, st_prev_q;
  logic [15:0]        lfsr_q;

  state_e             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               half_ph_q, half_ph_d;
  logic [1:0]         mole_cnt_q, mole_cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [N_MOLES-1:0] moles_q, moles_d;
  logic [6:0]         time_q, time_d;
  logic [13:0]        score_q, score_d;
  logic [7:0]         miss_q, miss_d;

  logic [N_MOLES-1:0] toggle;
  logic               start_rise, half_tick, sec_tick, mole_tick;
  logic               hit, toggle_miss, timeout_miss;
  logic [1:0]         per_m1;
  logic [IW-1:0]      lfsr_idx, next_idx;

  // Both switch directions count as a whack attempt.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      sw_prev_q <= '0;
      st_s1_q   <= 1'b0;
      st_s2_q   <= 1'b0;
      st_prev_q <= 1'b0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      sw_s1_q   <= switches_i;
      sw_s2_q   <= sw_s1_q;
      sw_prev_q <= sw_s2_q;
      st_s1_q   <= start_i;
      st_s2_q   <= st_s1_q;
      st_prev_q <= st_s2_q;
      lfsr_q    <= lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    end
  end

  assign toggle     = sw_s2_q ^ sw_prev_q;
  assign start_rise = st_s2_q & ~st_prev_q;
  assign half_tick  = (presc_q == PW'(HALF - 1));
  assign sec_tick   = half_tick & half_ph_q;
  assign mole_tick  = half_tick & (mole_cnt_q == per_m1);
  assign lfsr_idx   = IW'(lfsr_q % 16'(N_MOLES));

  always_comb begin
    case (mode_q)
      2'b01:   per_m1 = 2'd3;
      2'b10:   per_m1 = 2'd1;
      default: per_m1 = 2'd0;
    endcase
  end

  // A fresh mole never reappears at the index it just left.
  always_comb begin
    next_idx = lfsr_idx;
    if (lfsr_idx == idx_q)
      next_idx = (idx_q == IW'(N_MOLES - 1)) ? '0 : idx_q + IW'(1);
  end

  assign hit          = |(moles_q & toggle);
  assign toggle_miss  = ~hit & (|toggle);
  assign timeout_miss = mole_tick & (|moles_q) & ~hit;

  always_comb begin
    state_d    = state_q;
    presc_d    = half_tick ? '0 : presc_q + PW'(1);
    half_ph_d  = half_tick ? ~half_ph_q : half_ph_q;
    mole_cnt_d = mole_cnt_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    moles_d    = moles_q;
    time_d     = time_q;
    score_d    = score_q;
    miss_d     = miss_q;
    case (state_q)
      S_PLAY: begin
        if (half_tick) mole_cnt_d = mole_tick ? 2'd0 : mole_cnt_q + 2'd1;
        if (hit) begin
          score_d = sat_score_inc(score_q);
          moles_d = '0;
        end
        miss_d = sat_miss_add(miss_q, {1'b0, timeout_miss} + {1'b0, toggle_miss});
        if (mole_tick) begin
          idx_d   = next_idx;
          moles_d = N_MOLES'(1) << next_idx;
        end
        if (sec_tick) begin
          if (time_q == 7'd1) begin
            state_d = S_OVER;
            time_d  = '0;
            moles_d = '0;
          end else begin
            time_d = time_q - 7'd1;
          end
        end
      end
      default: begin
        if (start_rise && (mode_i != 2'b00)) begin
          state_d    = S_PLAY;
          presc_d    = '0;
          half_ph_d  = 1'b0;
          mole_cnt_d = '0;
          mode_d     = mode_i;
          idx_d      = lfsr_idx;
          moles_d    = N_MOLES'(1) << lfsr_idx;
          time_d     = 7'(GAME_SECONDS);
          score_d    = '0;
          miss_d     = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      half_ph_q  <= 1'b0;
      mole_cnt_q <= '0;
      mode_q     <= '0;
      idx_q      <= '0;
      moles_q    <= '0;
      time_q     <= 7'(GAME_SECONDS);
      score_q    <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      half_ph_q  <= half_ph_d;
      mole_cnt_q <= mole_cnt_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      moles_q    <= moles_d;
      time_q     <= time_d;
      score_q    <= score_d;
      miss_q     <= miss_d;
    end
  end

  assign moles_o     = moles_q;
  assign state_o     = state_q;
  assign time_left_o = time_q;
  assign score_o     = score_q;
  assign misses_o    = miss_q;
  assign display_o   = (state_q == S_PLAY) ? {7'b0, time_q} : score_q;

endmodule

// File: tb/tb_whack_game_core.sv
// Randomised scoreboard bench for whack_game_core against a behavioural game model.
module tb_whack_game_core;
  localparam int          N      = 6;
  localparam int          CLK_HZ = 8;
  localparam int          GAME_S = 60;
  localparam int          SMAX   = 8;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int          HALF   = CLK_HZ / 2;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [1:0]   mode_i;
  logic         start_i;
  logic [N-1:0] switches_i;
  logic [N-1:0] moles_o;
  logic [1:0]   state_o;
  logic [6:0]   time_left_o;
  logic [13:0]  score_o;
  logic [7:0]   misses_o;
  logic [13:0]  display_o;

  always #5 clk = ~clk;

  whack_game_core #(
    .N_MOLES(N), .CLK_HZ(CLK_HZ), .GAME_SECONDS(GAME_S), .SCORE_MAX(SMAX), .LFSR_SEED(SEED)
  ) dut (
    .clock_i(clk), .reset_i(reset_i), .mode_i(mode_i), .start_i(start_i),
    .switches_i(switches_i), .moles_o(moles_o), .state_o(state_o),
    .time_left_o(time_left_o), .score_o(score_o), .misses_o(misses_o), .display_o(display_o)
  );

  typedef struct { int st; int moles; int tl; int score; int miss; int disp; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int checks = 0, failures = 0, cyc = 0;

  // Game model: 0 idle, 1 play, 2 over; m_t counts edges since the game started.
  int           m_st, m_idx, m_t, m_tl, m_score, m_miss, m_mode;
  bit           m_lit;
  logic [15:0]  m_lfsr;
  logic [N-1:0] sw_h1, sw_h2, sw_h3, sw_cur;
  logic         st_h1, st_h2, st_h3;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic void m_reset();
    m_st = 0; m_idx = 0; m_t = 0; m_tl = GAME_S; m_score = 0; m_miss = 0; m_mode = 0;
    m_lit = 0; m_lfsr = SEED;
    sw_h1 = '0; sw_h2 = '0; sw_h3 = '0; st_h1 = 0; st_h2 = 0; st_h3 = 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st = m_st; e.moles = m_lit ? (1 << m_idx) : 0; e.tl = m_tl;
    e.score = m_score; e.miss = m_miss; e.disp = (m_st == 1) ? m_tl : m_score;
    return e;
  endfunction

  function automatic void model_step(input logic [N-1:0] sw, input logic st, input logic [1:0] md);
    logic [N-1:0] tog;
    bit rise, hit, tmiss, tmo, mtick;
    int per, ni;
    tog  = sw_h2 ^ sw_h3;
    rise = st_h2 && !st_h3;
    if (m_st != 1) begin
      if (rise && md != 2'b00) begin
        m_st = 1; m_score = 0; m_miss = 0; m_tl = GAME_S; m_t = 0; m_mode = int'(md);
        m_idx = int'(m_lfsr) % N; m_lit = 1;
      end
    end else begin
      m_t++;
      per   = (m_mode == 1) ? 4 : (m_mode == 2) ? 2 : 1;
      mtick = (m_t % (HALF * per)) == 0;
      hit   = m_lit && tog[m_idx];
      tmiss = !hit && (tog != '0);
      tmo   = mtick && m_lit && !hit;
      if (hit) begin
        if (m_score < SMAX) m_score++;
        m_lit = 0;
      end
      m_miss = m_miss + int'(tmiss) + int'(tmo);
      if (m_miss > 255) m_miss = 255;
      if (mtick) begin
        ni = int'(m_lfsr) % N;
        if (ni == m_idx) ni = (ni + 1) % N;
        m_idx = ni; m_lit = 1;
      end
      if (m_t % (2 * HALF) == 0) begin
        if (m_tl == 1) begin m_tl = 0; m_st = 2; m_lit = 0; end
        else m_tl--;
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
    sw_h3 = sw_h2; sw_h2 = sw_h1; sw_h1 = sw;
    st_h3 = st_h2; st_h2 = st_h1; st_h1 = st;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, cyc, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("state",     int'(state_o),     mon_e.st);
      chk("moles",     int'(moles_o),     mon_e.moles);
      chk("time_left", int'(time_left_o), mon_e.tl);
      chk("score",     int'(score_o),     mon_e.score);
      chk("misses",    int'(misses_o),    mon_e.miss);
      chk("display",   int'(display_o),   mon_e.disp);
    end
  end

  task automatic cycle(input logic [N-1:0] sw, input logic st, input logic [1:0] md, input logic rst);
    exp_t e;
    switches_i = sw; start_i = st; mode_i = md; reset_i = rst;
    if (!rst) m_reset();
    else model_step(sw, st, md);
    e = model_out();
    @(posedge clk);
    q.push_back(e);
    cyc++;
    #1;
  endtask

  task automatic start_game(input logic [1:0] md);
    repeat (4) cycle(sw_cur, 1'b1, md, 1'b1);
    cycle(sw_cur, 1'b0, md, 1'b1);
  endtask

  task automatic play(input bit aggr, input int max_cyc, input bit expect_end);
    int n, b;
    logic [1:0] md;
    logic st;
    n = 0;
    while (m_st == 1 && n < max_cyc) begin
      md = 2'($urandom);
      st = (m_tl > 5) && ($urandom_range(0, 15) == 0);
      b  = $urandom_range(0, N - 1);
      if (aggr) begin
        if (m_lit && $urandom_range(0, 1) == 1) sw_cur[m_idx] = ~sw_cur[m_idx];
        else sw_cur[b] = ~sw_cur[b];
      end else begin
        case ($urandom_range(0, 5))
          0, 1: if (m_lit) sw_cur[m_idx] = ~sw_cur[m_idx];
          2: sw_cur[b] = ~sw_cur[b];
          default: ;
        endcase
      end
      cycle(sw_cur, st, md, 1'b1);
      n++;
    end
    if (expect_end && m_st != 2) begin
      failures++;
      $display("FAIL game_end_bound cycle=%0d actual_state=%0d expected=2", cyc, int'(state_o));
    end
  endtask

  initial begin
    reset_i = 1'b0; mode_i = 2'b00; start_i = 1'b0; switches_i = '0; sw_cur = '0;
    m_reset();
    repeat (3) cycle(sw_cur, 1'b0, 2'b00, 1'b0);

    // Start presses with mode 00 must be ignored.
    for (int i = 0; i < 24; i++) begin
      sw_cur = N'($urandom);
      cycle(sw_cur, (i % 6) < 3, 2'b00, 1'b1);
    end

    start_game(2'b10);
    play(1'b0, 800, 1'b1);

    // Restart from OVER in fast mode with heavy toggling to reach both saturation limits.
    repeat (5) cycle(sw_cur, 1'b0, 2'b11, 1'b1);
    start_game(2'b11);
    play(1'b1, 800, 1'b1);

    repeat (5) cycle(sw_cur, 1'b0, 2'b00, 1'b1);
    start_game(2'b01);
    play(1'b0, 60, 1'b0);

    // Asynchronous reset between edges; the pending expectation becomes the reset state.
    #1;
    reset_i = 1'b0;
    m_reset();
    void'(q.pop_back());
    q.push_back(model_out());
    repeat (3) cycle(sw_cur, 1'b0, 2'b00, 1'b0);

    start_game(2'b11);
    play(1'b1, 40, 1'b0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
